// File: rtl/regs_mp.sv
// regs_mp: parametrised register file with two combinational read ports, one core
// write port, optional write-to-read bypass and a handshaked debug access port.
// The array has no per-bit reset; a hardware sweep clears it after reset.
module regs_mp #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned NREG     = 32,
  parameter int unsigned AW       = $clog2(NREG),
  parameter bit          ZERO_REG = 1'b1,
  parameter bit          BYPASS   = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [AW-1:0]   reg1_raddr_i,
  input  logic [AW-1:0]   reg2_raddr_i,
  output logic [XLEN-1:0] reg1_rdata_o,
  output logic [XLEN-1:0] reg2_rdata_o,
  input  logic            we_i,
  input  logic [AW-1:0]   waddr_i,
  input  logic [XLEN-1:0] wdata_i,
  input  logic            dbg_req_i,
  input  logic            dbg_we_i,
  input  logic [AW-1:0]   dbg_addr_i,
  input  logic [XLEN-1:0] dbg_wdata_i,
  output logic            dbg_ack_o,
  output logic [XLEN-1:0] dbg_rdata_o,
  output logic            ready_o
);

  // One extra bit so NREG itself is representable when it equals 2**AW.
  localparam logic [AW:0]   NregW   = (AW + 1)'(NREG);
  localparam logic [AW-1:0] LastReg = AW'(NREG - 1);

  typedef enum logic {StInit, StRun} main_state_e;
  typedef enum logic {StIdle, StAck} dbg_state_e;

  main_state_e     main_state, main_next;
  dbg_state_e      dbg_state, dbg_next;
  logic [AW-1:0]   clr_ptr, clr_ptr_next;
  logic [XLEN-1:0] mem [NREG];

  logic core_wr;
  logic dbg_accept;
  logic dbg_wr;
  logic dbg_rd;

  // Address is a real, writable entry (in range and not the hardwired zero).
  function automatic logic addr_ok(input logic [AW-1:0] a);
    return ({1'b0, a} < NregW) && !(ZERO_REG && (a == '0));
  endfunction

  // Read-port value rule; use_byp selects whether an in-flight core write forwards.
  function automatic logic [XLEN-1:0] read_rule(input logic [AW-1:0] a, input logic use_byp);
    logic [XLEN-1:0] r;
    r = '0;
    if (ready_o && addr_ok(a)) begin
      if (use_byp && BYPASS && core_wr && (waddr_i == a)) r = wdata_i;
      else                                                r = mem[a];
    end
    return r;
  endfunction

  assign ready_o    = (main_state == StRun);
  assign dbg_ack_o  = (dbg_state == StAck);
  assign core_wr    = ready_o && we_i && addr_ok(waddr_i);
  // Core writes win; debug only gets a slot when WB is idle.
  assign dbg_accept = (dbg_state == StIdle) && dbg_req_i && ready_o && !we_i;
  assign dbg_wr     = dbg_accept && dbg_we_i && addr_ok(dbg_addr_i);
  assign dbg_rd     = dbg_accept && !dbg_we_i;

  // Main FSM and sweep pointer state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_state <= StInit;
      clr_ptr    <= '0;
    end else begin
      main_state <= main_next;
      clr_ptr    <= clr_ptr_next;
    end
  end

  // Sweep advances one entry per edge and hands over to RUN after the last one.
  always_comb begin
    main_next    = main_state;
    clr_ptr_next = clr_ptr;
    unique case (main_state)
      StInit: begin
        clr_ptr_next = clr_ptr + AW'(1);
        if (clr_ptr == LastReg) main_next = StRun;
      end
      StRun: main_next = StRun;
      default: main_next = StInit;
    endcase
  end

  // Storage array: sweep clear, else core write, else debug write.
  always_ff @(posedge clk) begin
    if (!ready_o)     mem[clr_ptr]    <= '0;
    else if (core_wr) mem[waddr_i]    <= wdata_i;
    else if (dbg_wr)  mem[dbg_addr_i] <= dbg_wdata_i;
  end

  // Debug FSM state and read-data capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dbg_state   <= StIdle;
      dbg_rdata_o <= '0;
    end else begin
      dbg_state <= dbg_next;
      if (dbg_rd) dbg_rdata_o <= read_rule(dbg_addr_i, 1'b0);
    end
  end

  // Accept in IDLE, spend exactly one cycle in ACK.
  always_comb begin
    dbg_next = dbg_state;
    unique case (dbg_state)
      StIdle:  if (dbg_accept) dbg_next = StAck;
      StAck:   dbg_next = StIdle;
      default: dbg_next = StIdle;
    endcase
  end

  // Combinational read ports.
  always_comb begin
    reg1_rdata_o = read_rule(reg1_raddr_i, 1'b1);
    reg2_rdata_o = read_rule(reg2_raddr_i, 1'b1);
  end

endmodule

// File: tb/tb_regs_mp.sv
// Bench for regs_mp: two instances (32 regs, zero reg, bypass / 24 regs, no zero reg,
// no bypass) on shared stimulus, checked every cycle against a behavioural model.
module tb_regs_mp;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [4:0]  raddr1 = '0, raddr2 = '0, waddr = '0, dbg_addr = '0;
  logic        we = 1'b0, dbg_req = 1'b0, dbg_we = 1'b0;
  logic [31:0] wdata = '0, dbg_wdata = '0;

  logic [31:0] rd1_a, rd2_a, drd_a, rd1_b, rd2_b, drd_b;
  logic        ack_a, rdy_a, ack_b, rdy_b;

  int n_cmp = 0;
  int n_fail = 0;
  bit checking = 1'b0;

  always #5 clk = ~clk;

  regs_mp #(.XLEN(32), .NREG(32), .ZERO_REG(1'b1), .BYPASS(1'b1)) dut_a (
    .clk(clk), .rst(rst),
    .reg1_raddr_i(raddr1), .reg2_raddr_i(raddr2),
    .reg1_rdata_o(rd1_a), .reg2_rdata_o(rd2_a),
    .we_i(we), .waddr_i(waddr), .wdata_i(wdata),
    .dbg_req_i(dbg_req), .dbg_we_i(dbg_we), .dbg_addr_i(dbg_addr), .dbg_wdata_i(dbg_wdata),
    .dbg_ack_o(ack_a), .dbg_rdata_o(drd_a), .ready_o(rdy_a)
  );

  regs_mp #(.XLEN(32), .NREG(24), .ZERO_REG(1'b0), .BYPASS(1'b0)) dut_b (
    .clk(clk), .rst(rst),
    .reg1_raddr_i(raddr1), .reg2_raddr_i(raddr2),
    .reg1_rdata_o(rd1_b), .reg2_rdata_o(rd2_b),
    .we_i(we), .waddr_i(waddr), .wdata_i(wdata),
    .dbg_req_i(dbg_req), .dbg_we_i(dbg_we), .dbg_addr_i(dbg_addr), .dbg_wdata_i(dbg_wdata),
    .dbg_ack_o(ack_b), .dbg_rdata_o(drd_b), .ready_o(rdy_b)
  );

  // ---------------- behavioural model ----------------
  int          nreg_m [2] = '{32, 24};
  bit          zr_m   [2] = '{1'b1, 1'b0};
  bit          byp_m  [2] = '{1'b1, 1'b0};
  int          cnt    [2] = '{0, 0};       // edges seen since reset released
  bit          mack   [2] = '{1'b0, 1'b0};
  logic [31:0] mdrd   [2] = '{32'h0, 32'h0};
  logic [31:0] mmem   [2][64];

  function automatic bit m_ready(int i);
    return cnt[i] >= nreg_m[i];
  endfunction

  function automatic bit m_legal(int i, int a);
    return m_ready(i) && (a < nreg_m[i]) && !(zr_m[i] && a == 0);
  endfunction

  function automatic logic [31:0] m_read(int i, int a, bit use_byp);
    if (!m_ready(i) || !m_legal(i, a)) return 32'h0;
    if (use_byp && byp_m[i] && we && m_legal(i, int'(waddr)) && int'(waddr) == a) return wdata;
    return mmem[i][a];
  endfunction

  task automatic model_step(int i);
    logic [31:0] rv;
    bit          core_wr;
    if (!m_ready(i)) begin
      cnt[i]++;
      // Whole file reads as zero once the sweep completes.
      if (cnt[i] == nreg_m[i]) for (int a = 0; a < 64; a++) mmem[i][a] = 32'h0;
    end else begin
      rv      = m_read(i, int'(dbg_addr), 1'b0);
      core_wr = we && m_legal(i, int'(waddr));
      if (mack[i]) mack[i] = 1'b0;
      else if (dbg_req && !we) begin
        mack[i] = 1'b1;
        if (dbg_we) begin
          if (m_legal(i, int'(dbg_addr))) mmem[i][dbg_addr] = dbg_wdata;
        end else mdrd[i] = rv;
      end
      if (core_wr) mmem[i][waddr] = wdata;
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        cnt[i] = 0; mack[i] = 1'b0; mdrd[i] = 32'h0;
      end
    end else begin
      model_step(0);
      model_step(1);
    end
  end

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cmp_inst(int i, logic [31:0] r1, logic [31:0] r2, logic rdy, logic ack,
                          logic [31:0] drd);
    string s;
    s = (i == 0) ? "a" : "b";
    chk({"rd1_", s}, r1, m_read(i, int'(raddr1), 1'b1));
    chk({"rd2_", s}, r2, m_read(i, int'(raddr2), 1'b1));
    chk({"ready_", s}, {31'h0, rdy}, {31'h0, m_ready(i)});
    chk({"ack_", s}, {31'h0, ack}, {31'h0, mack[i]});
    chk({"drd_", s}, drd, mdrd[i]);
  endtask

  always @(negedge clk) begin
    if (checking) begin
      cmp_inst(0, rd1_a, rd2_a, rdy_a, ack_a, drd_a);
      cmp_inst(1, rd1_b, rd2_b, rdy_b, ack_b, drd_b);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int n_a, n_b;

  initial begin
    #1 rst = 1'b1;
    repeat (2) tick();
    checking = 1'b1;
    chk("rst_ready", {31'h0, rdy_a}, 32'h0);
    chk("rst_ack", {31'h0, ack_a}, 32'h0);
    chk("rst_drd", drd_a, 32'h0);

    // Sweep; core write to x5 held during INIT must be lost.
    rst = 1'b0; we = 1'b1; waddr = 5'd5; wdata = 32'h55;
    n_a = 0; n_b = 0;
    for (int n = 1; n <= 40; n++) begin
      tick();
      if (rdy_b && n_b == 0) begin n_b = n; we = 1'b0; end
      if (rdy_a && n_a == 0) begin n_a = n; break; end
    end
    chk("sweep_len_a", n_a, 32);
    chk("sweep_len_b", n_b, 24);
    raddr1 = 5'd5; #1;
    chk("x5_lost_a", rd1_a, 32'h0);
    chk("x5_lost_b", rd1_b, 32'h0);

    // Write x7 with same-cycle read.
    raddr1 = 5'd7; we = 1'b1; waddr = 5'd7; wdata = 32'hDEADBEEF; #1;
    chk("bypass_a", rd1_a, 32'hDEADBEEF);
    chk("nobypass_b", rd1_b, 32'h0);
    tick(); we = 1'b0; #1;
    chk("after_wr_b", rd1_b, 32'hDEADBEEF);

    // Zero register.
    raddr1 = 5'd0; raddr2 = 5'd0; we = 1'b1; waddr = 5'd0; wdata = 32'h12345678; #1;
    chk("x0_byp_rd1_a", rd1_a, 32'h0);
    chk("x0_byp_rd2_a", rd2_a, 32'h0);
    tick(); we = 1'b0; #1;
    chk("x0_a", rd1_a, 32'h0);
    chk("x0_b", rd1_b, 32'h12345678);

    // Debug read starved by core writes, then served.
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 5'd7;
    we = 1'b1; waddr = 5'd3; wdata = 32'h33;
    repeat (3) begin tick(); chk("dbg_starve", {31'h0, ack_a}, 32'h0); end
    we = 1'b0;
    tick();
    chk("dbg_ack", {31'h0, ack_a}, 32'h1);
    chk("dbg_rdata_a", drd_a, 32'hDEADBEEF);
    chk("dbg_rdata_b", drd_b, 32'hDEADBEEF);
    dbg_req = 1'b0;
    tick();
    chk("dbg_ack_end", {31'h0, ack_a}, 32'h0);

    // Debug write x9.
    raddr2 = 5'd9; dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 5'd9; dbg_wdata = 32'hA5A5A5A5;
    tick();
    chk("dbgwr_ack", {31'h0, ack_a}, 32'h1);
    dbg_req = 1'b0; #1;
    chk("dbgwr_rd2_a", rd2_a, 32'hA5A5A5A5);
    tick();
    chk("dbgwr_rd2_b", rd2_b, 32'hA5A5A5A5);

    // Address 30: out of range for the 24-entry file.
    raddr1 = 5'd30; we = 1'b1; waddr = 5'd30; wdata = 32'h77; #1;
    chk("oor_byp_b", rd1_b, 32'h0);
    chk("x30_byp_a", rd1_a, 32'h77);
    tick(); we = 1'b0; #1;
    chk("oor_rd_b", rd1_b, 32'h0);
    chk("x30_rd_a", rd1_a, 32'h77);
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 5'd30;
    tick();
    chk("oor_dbg_ack_b", {31'h0, ack_b}, 32'h1);
    chk("oor_dbg_rd_b", drd_b, 32'h0);
    chk("x30_dbg_rd_a", drd_a, 32'h77);
    dbg_req = 1'b0;
    tick();
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_wdata = 32'h99;
    tick();
    chk("oor_dbgwr_ack_b", {31'h0, ack_b}, 32'h1);
    dbg_req = 1'b0;
    tick();
    chk("oor_dbgwr_b", rd1_b, 32'h0);
    chk("x30_dbgwr_a", rd1_a, 32'h99);

    // Held request: one access every two cycles.
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 5'd9;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("held_ack", {31'h0, ack_a}, (k % 2 == 0) ? 32'h1 : 32'h0);
    end
    dbg_req = 1'b0;
    chk("held_rdata", drd_a, 32'hA5A5A5A5);
    tick();

    // Reset in the ack cycle.
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 5'd7;
    tick();
    chk("pre_rst_ack", {31'h0, ack_a}, 32'h1);
    rst = 1'b1; #1;
    chk("rst_mid_ack", {31'h0, ack_a}, 32'h0);
    chk("rst_mid_ready", {31'h0, rdy_a}, 32'h0);
    chk("rst_mid_drd", drd_a, 32'h0);
    dbg_req = 1'b0;
    tick();
    rst = 1'b0; raddr1 = 5'd7;
    n_a = 0;
    for (int n = 1; n <= 40; n++) begin
      tick();
      if (rdy_a) begin n_a = n; break; end
    end
    chk("resweep_len_a", n_a, 32);
    #1;
    chk("x7_cleared_a", rd1_a, 32'h0);
    chk("x7_cleared_b", rd1_b, 32'h0);
    repeat (3) tick();

    checking = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/regs_mp.md
# regs_mp

Parametrised general-purpose register file for the core: two combinational read ports feeding ID, one synchronous write port from WB, optional write-to-read bypass, and a handshaked debug access port. After reset it clears every entry with a hardware sweep, so the storage array needs no per-bit reset and can map to distributed RAM. It replaces the fixed 32x32 read-only register bank between ID and WB.

## Interface
Parameters:
- XLEN, 32, data width in bits
- NREG, 32, number of registers (2..64, need not be a power of two)
- AW, $clog2(NREG), register address width (derived)
- ZERO_REG, 1, 1 = entry 0 hardwired to zero (reads 0, writes dropped)
- BYPASS, 1, 1 = same-cycle write data forwarded to matching read ports

Ports:
- clk  input  1  clock, all state on rising edge
- rst  input  1  asynchronous, active-high reset
- reg1_raddr_i  input  AW  read port 1 address (from ID)
- reg2_raddr_i  input  AW  read port 2 address (from ID)
- reg1_rdata_o  output  XLEN  read port 1 data (to ID)
- reg2_rdata_o  output  XLEN  read port 2 data (to ID)
- we_i  input  1  core write enable (from WB)
- waddr_i  input  AW  core write address
- wdata_i  input  XLEN  core write data
- dbg_req_i  input  1  debug request, held until dbg_ack_o
- dbg_we_i  input  1  debug access type: 1 write, 0 read
- dbg_addr_i  input  AW  debug address
- dbg_wdata_i  input  XLEN  debug write data
- dbg_ack_o  output  1  one-cycle debug completion pulse
- dbg_rdata_o  output  XLEN  debug read data, valid with dbg_ack_o, held until next debug read
- ready_o  output  1  clear sweep complete, file usable

## Operation
- Main FSM: INIT, RUN. Reset -> INIT, clr_ptr=0.
- INIT: each edge writes 0 to entry clr_ptr, clr_ptr++; on the edge clearing entry NREG-1 go to RUN. RUN is held until next reset.
- Reset values: ready_o=0, dbg_ack_o=0, dbg_rdata_o=0, debug FSM IDLE, clr_ptr=0. Array contents not reset.
- Reads (combinational, both ports identical): 0 if !ready_o; 0 if ZERO_REG and raddr==0; 0 if raddr>=NREG; wdata_i if BYPASS, we_i, waddr_i==raddr and write is legal; else array[raddr].
- Legal core write: ready_o & we_i & waddr_i<NREG & !(ZERO_REG & waddr_i==0). Only legal writes update the array and only legal writes are bypassed.
- During INIT core writes ignored and debug requests not accepted.
- Debug FSM: IDLE, ACK.
  - IDLE: accept when dbg_req_i & ready_o & !we_i (core write has priority; debug may starve while WB writes every cycle).
  - On accept edge: write dbg_wdata_i if dbg_we_i (same legality as core: reg0/out-of-range dropped); else load dbg_rdata_o with the read-port value rule without bypass. Go to ACK.
  - ACK: dbg_ack_o=1 for this one cycle, no accept; next edge -> IDLE.
  - Debug writes to dropped addresses still acknowledged.
- Reset mid-operation (any state): immediate return to reset values, pending debug access discarded without ack, sweep restarts at entry 0.

## Timing
- Read latency 0 (combinational address -> data).
- Core write visible via array on cycle after the write edge; same cycle via bypass when BYPASS=1; with BYPASS=0 the read returns the old value during the write cycle.
- ready_o rises after exactly NREG rising edges following reset deassertion.
- Debug: ack in the cycle after the accept edge; minimum request-to-ack 1 cycle; held dbg_req_i yields back-to-back accesses every 2 cycles; requester must drop or change dbg_req_i in the ack cycle to avoid a repeat access.
- No combinational path from dbg_* inputs to any output.

## Test plan
- Reset sweep: NREG=32, drive rst 1->0 -> ready_o=0 for 32 edges, rises on 32nd; all reads return 0 during and after sweep; core write to x5 during INIT is lost (x5 reads 0 after ready).
- Write/bypass: write x7=0xDEADBEEF with reg1_raddr_i=7 same cycle -> reg1_rdata_o=0xDEADBEEF that cycle (BYPASS=1) / 0 that cycle then 0xDEADBEEF (BYPASS=0).
- Zero register: write x0=0x12345678 with ZERO_REG=1 -> both ports read 0 at addr 0, no bypass; ZERO_REG=0 -> reads 0x12345678.
- Debug: hold dbg_req_i read of x7 while we_i=1 for 3 cycles -> no ack; we_i drops -> ack 1 cycle later, dbg_rdata_o=0xDEADBEEF; debug write x9=0xA5A5A5A5 -> reg2 reads it after ack.
- Non-power-of-two: NREG=24 -> sweep 24 cycles; write/read addr 30 -> dropped, reads 0, debug access acked with dbg_rdata_o=0.
- Reset mid-access: assert rst in the cycle after debug accept -> dbg_ack_o=0 immediately, ready_o=0, sweep restarts; previously written x7 reads 0 after ready.
